hpdcache_mem_arbiter: RTL and testbench
=======================================

Name: hpdcache_mem_arbiter

Overview:
- Shares the single word-wide backing-memory port (UART-bridged main memory, 32-bit address/data) between the data cache's refill (read) channel and write-back (write) channel.
- Accepts burst requests on either channel, serialises them into single-word memory transactions, and returns tagged read data and write acknowledgements to the cache.
- Sits between the cache memory interface and the memory/UART bridge.
- Round-robin grant, one burst in flight at a time.

Parameters:
- ADDR_WIDTH, 32: memory byte address width.
- DATA_WIDTH, 32: memory word width; beat address stride is DATA_WIDTH/8.
- ID_WIDTH, 6: transaction ID width, returned unchanged in responses.
- LEN_WIDTH, 8: burst length field width; a burst carries len+1 beats.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rd_req_valid_i/rd_req_ready_o  in/out  1/1  read request handshake
- rd_req_addr_i  in  ADDR_WIDTH  first-beat byte address, word aligned
- rd_req_len_i  in  LEN_WIDTH  beats-1
- rd_req_id_i  in  ID_WIDTH  read transaction ID
- rd_resp_valid_o/rd_resp_ready_i  out/in  1/1  read response handshake
- rd_resp_data_o  out  DATA_WIDTH  read beat data
- rd_resp_id_o  out  ID_WIDTH  echoed read ID
- rd_resp_last_o  out  1  final beat of the burst
- wr_req_valid_i/wr_req_ready_o  in/out  1/1  write request handshake
- wr_req_addr_i  in  ADDR_WIDTH  first-beat byte address
- wr_req_len_i  in  LEN_WIDTH  beats-1
- wr_req_id_i  in  ID_WIDTH  write transaction ID
- wdata_valid_i/wdata_ready_o  in/out  1/1  write data handshake
- wdata_i  in  DATA_WIDTH  write beat data
- wdata_be_i  in  DATA_WIDTH/8  byte enables for the beat
- wdata_last_i  in  1  sender marks final beat
- wr_resp_valid_o/wr_resp_ready_i  out/in  1/1  write acknowledge handshake
- wr_resp_id_o  out  ID_WIDTH  echoed write ID
- wr_resp_err_o  out  1  wdata_last mismatch detected
- mem_valid_o/mem_ready_i  out/in  1/1  memory command handshake
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_WIDTH  word byte address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_be_o  out  DATA_WIDTH/8  byte enables; all-ones on reads
- mem_rvalid_i  in  1  read data valid; exactly one per accepted read, in order
- mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP.
- Reset state:
  - FSM in IDLE; priority register = READ.
  - Beat counter, address, ID, data and error registers cleared.
  - All valid/ready outputs 0; all data outputs 0.
- IDLE, grant selection:
  - Only read pending: grant read. Only write pending: grant write.
  - Both pending: grant the channel named by the priority register.
  - The granted request's ready is asserted combinationally in the same cycle.
  - On grant: latch addr/len/id, clear beat counter and error flag, set priority to the other channel.
  - Next state: RD_ISSUE for read, WR_DATA for write.
  - No request pending: stay in IDLE; priority unchanged.
- RD_ISSUE:
  - mem_valid_o=1, mem_we_o=0, mem_be_o all-ones, mem_addr_o = current address.
  - On mem_ready_i, go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid_i, capture mem_rdata_i and go to RD_RESP.
  - mem_rvalid_i in any other state is ignored.
- RD_RESP:
  - rd_resp_valid_o=1 with the captured data and latched ID; rd_resp_last_o = (beat == len).
  - On rd_resp_ready_i: if last, go to IDLE; otherwise address += DATA_WIDTH/8, beat += 1, go to RD_ISSUE.
  - Data and ID stay stable while the response is stalled.
- WR_DATA:
  - mem_valid_o = wdata_valid_i; mem_we_o=1; mem_wdata_o/mem_be_o driven from wdata_i/wdata_be_i.
  - wdata_ready_o = mem_ready_i, i.e. a beat is consumed only when memory accepts it.
  - Beat consumed at beat == len: set error if !wdata_last_i, then go to WR_RESP.
  - Beat consumed at beat < len: set error if wdata_last_i, advance address and beat, stay in WR_DATA.
  - The latched len is authoritative; the error flag is sticky for the burst.
- WR_RESP:
  - wr_resp_valid_o=1 with latched ID and the error flag.
  - On wr_resp_ready_i, go to IDLE.
- Address arithmetic: increments by DATA_WIDTH/8 modulo 2^ADDR_WIDTH. Wrap from 0xFFFFFFFC to 0x0 is allowed, with no error.
- Maximum burst is 2^LEN_WIDTH beats; beat counter width is LEN_WIDTH.
- Request readies are 0 outside IDLE; wdata_ready_o is 0 outside WR_DATA.
- Minimum read-beat latency: memory latency + 2 cycles (issue, capture, response). Write beats can sustain one per cycle.
- Reset asserted mid-burst: the burst is abandoned and all state returns to the reset values on the next edge. No response is ever emitted for the abandoned burst.

Test Plan:
- Read len=0 at 0x100, ID 5, memory returns 0xDEADBEEF after 3 cycles -> one response: data 0xDEADBEEF, ID 5, last=1; mem_be_o = 0xF.
- 8-beat read at 0x2000 with rd_resp_ready toggling -> memory addresses 0x2000..0x201C in order; 8 responses, last only on the 8th; data stable while stalled.
- Read and write both valid in the same cycle after reset -> read granted first; with both valid again afterwards, write granted next (alternation).
- 4-beat write at 0x40, ID 3, with mem_ready stalls and be=0x3 on beat 2 -> 4 memory writes at 0x40/44/48/4C carrying matching data/be; wr_resp ID 3, err=0.
- 4-beat write with wdata_last on beat 2 -> 4 beats still written; wr_resp err=1.
- rst_i asserted during beat 3 of an 8-beat read -> all valids 0 next cycle; no rd_resp; a new read is then accepted normally.

Source files
------------

// File: rtl/hpdcache_mem_arbiter.sv
// hpdcache_mem_arbiter
//
// Shares one word-wide backing-memory port between the data cache's refill
// (read) channel and its write-back (write) channel. Burst requests are
// granted round-robin, one burst at a time, and split into single-word
// memory transactions. Read beats return as tagged responses; a write burst
// ends with one acknowledge that flags any wdata_last_i mismatch.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rd_req_*                read burst request (addr, len = beats-1, id)
//   rd_resp_*               read beat response (data, id, last)
//   wr_req_*                write burst request (addr, len = beats-1, id)
//   wdata_*                 write beat stream (data, byte enables, last)
//   wr_resp_*               write burst acknowledge (id, err)
//   mem_*                   single-word memory command port; mem_rvalid_i
//                           returns one word per accepted read, in order
module hpdcache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    rd_req_valid_i,
    output logic                    rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
    input  logic [LEN_WIDTH-1:0]    rd_req_len_i,
    input  logic [ID_WIDTH-1:0]     rd_req_id_i,

    output logic                    rd_resp_valid_o,
    input  logic                    rd_resp_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_resp_data_o,
    output logic [ID_WIDTH-1:0]     rd_resp_id_o,
    output logic                    rd_resp_last_o,

    input  logic                    wr_req_valid_i,
    output logic                    wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
    input  logic [LEN_WIDTH-1:0]    wr_req_len_i,
    input  logic [ID_WIDTH-1:0]     wr_req_id_i,

    input  logic                    wdata_valid_i,
    output logic                    wdata_ready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wdata_be_i,
    input  logic                    wdata_last_i,

    output logic                    wr_resp_valid_o,
    input  logic                    wr_resp_ready_i,
    output logic [ID_WIDTH-1:0]     wr_resp_id_o,
    output logic                    wr_resp_err_o,

    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0]  BEAT_ONE    = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_e;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

    state_e                  state_q, state_d;
    prio_e                   prio_q,  prio_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [LEN_WIDTH-1:0]    len_q,   len_d;
    logic [LEN_WIDTH-1:0]    beat_q,  beat_d;
    logic [ID_WIDTH-1:0]     id_q,    id_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q,   err_d;

    logic beat_last;
    logic grant_rd;
    logic grant_wr;

    assign beat_last = (beat_q == len_q);

    // Grants are suppressed while reset is held so no request handshake can
    // complete in a cycle whose state update is discarded.
    assign grant_rd = (state_q == IDLE) && !rst_i && rd_req_valid_i &&
                      (!wr_req_valid_i || prio_q == PRIO_READ);
    assign grant_wr = (state_q == IDLE) && !rst_i && wr_req_valid_i && !grant_rd;

    // Latched burst context is presented directly; it is zero after reset.
    assign rd_resp_data_o = rdata_q;
    assign rd_resp_id_o   = id_q;
    assign wr_resp_id_o   = id_q;
    assign wr_resp_err_o  = err_q;
    assign mem_addr_o     = addr_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d         = state_q;
        prio_d          = prio_q;
        addr_d          = addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        id_d            = id_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        rd_req_ready_o  = 1'b0;
        wr_req_ready_o  = 1'b0;
        wdata_ready_o   = 1'b0;
        rd_resp_valid_o = 1'b0;
        rd_resp_last_o  = 1'b0;
        wr_resp_valid_o = 1'b0;
        mem_valid_o     = 1'b0;
        mem_we_o        = 1'b0;
        mem_wdata_o     = '0;
        mem_be_o        = '0;

        case (state_q)
            IDLE: begin
                rd_req_ready_o = grant_rd;
                wr_req_ready_o = grant_wr;
                if (grant_rd) begin
                    addr_d  = rd_req_addr_i;
                    len_d   = rd_req_len_i;
                    id_d    = rd_req_id_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    prio_d  = PRIO_WRITE;
                    state_d = RD_ISSUE;
                end else if (grant_wr) begin
                    addr_d  = wr_req_addr_i;
                    len_d   = wr_req_len_i;
                    id_d    = wr_req_id_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    prio_d  = PRIO_READ;
                    state_d = WR_DATA;
                end
            end

            RD_ISSUE: begin
                mem_valid_o = 1'b1;
                mem_be_o    = '1;
                if (mem_ready_i) state_d = RD_WAIT;
            end

            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = RD_RESP;
                end
            end

            RD_RESP: begin
                rd_resp_valid_o = 1'b1;
                rd_resp_last_o  = beat_last;
                if (rd_resp_ready_i) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_STRIDE;
                        beat_d  = beat_q + BEAT_ONE;
                        state_d = RD_ISSUE;
                    end
                end
            end

            WR_DATA: begin
                // Beats pass straight through; one is consumed only when the
                // memory takes it, which allows one beat per cycle.
                mem_valid_o   = wdata_valid_i;
                mem_we_o      = 1'b1;
                mem_wdata_o   = wdata_i;
                mem_be_o      = wdata_be_i;
                wdata_ready_o = mem_ready_i;
                if (wdata_valid_i && mem_ready_i) begin
                    // The latched length decides where the burst ends; a
                    // disagreeing wdata_last_i only sets the sticky error.
                    if (beat_last) begin
                        err_d   = err_q | ~wdata_last_i;
                        state_d = WR_RESP;
                    end else begin
                        err_d  = err_q | wdata_last_i;
                        addr_d = addr_q + ADDR_STRIDE;
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end

            WR_RESP: begin
                wr_resp_valid_o = 1'b1;
                if (wr_resp_ready_i) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= PRIO_READ;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_hpdcache_mem_arbiter.sv
// tb_hpdcache_mem_arbiter
//
// Scoreboard bench for hpdcache_mem_arbiter. Request tasks push the expected
// memory commands and responses into per-channel queues when a burst is
// issued; independent monitors pop and compare on every handshake. A simple
// memory model answers reads with a content function of the address.
module tb_hpdcache_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int IW     = 6;
    localparam int LW     = 8;
    localparam int BW     = DW / 8;
    localparam int BUDGET = 4000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rd_req_valid_i, rd_req_ready_o;
    logic [AW-1:0] rd_req_addr_i;
    logic [LW-1:0] rd_req_len_i;
    logic [IW-1:0] rd_req_id_i;
    logic          rd_resp_valid_o, rd_resp_ready_i;
    logic [DW-1:0] rd_resp_data_o;
    logic [IW-1:0] rd_resp_id_o;
    logic          rd_resp_last_o;
    logic          wr_req_valid_i, wr_req_ready_o;
    logic [AW-1:0] wr_req_addr_i;
    logic [LW-1:0] wr_req_len_i;
    logic [IW-1:0] wr_req_id_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [DW-1:0] wdata_i;
    logic [BW-1:0] wdata_be_i;
    logic          wdata_last_i;
    logic          wr_resp_valid_o, wr_resp_ready_i;
    logic [IW-1:0] wr_resp_id_o;
    logic          wr_resp_err_o;
    logic          mem_valid_o, mem_ready_i, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    hpdcache_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
        .rd_resp_valid_o(rd_resp_valid_o), .rd_resp_ready_i(rd_resp_ready_i),
        .rd_resp_data_o(rd_resp_data_o), .rd_resp_id_o(rd_resp_id_o), .rd_resp_last_o(rd_resp_last_o),
        .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
        .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wdata_be_i(wdata_be_i), .wdata_last_i(wdata_last_i),
        .wr_resp_valid_o(wr_resp_valid_o), .wr_resp_ready_i(wr_resp_ready_i),
        .wr_resp_id_o(wr_resp_id_o), .wr_resp_err_o(wr_resp_err_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory content and expectation queues ----------------
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct packed { logic [31:0] data; logic [IW-1:0] id; logic last; } rd_exp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [BW-1:0] be; } wr_cmd_t;
    typedef struct packed { logic [IW-1:0] id; logic err; } wr_exp_t;

    rd_exp_t     rd_resp_q[$];
    logic [31:0] rd_cmd_q[$];
    wr_cmd_t     wr_cmd_q[$];
    wr_exp_t     wr_resp_q[$];
    int          grant_log[$];
    int          rd_resp_cnt = 0;

    int mem_lat    = -1;   // <0: random 0..3 extra cycles
    int ready_pct  = 70;
    int rresp_pct  = 60;

    logic [31:0]   wd  [256];
    logic [BW-1:0] wbe [256];
    logic          wl  [256];

    // ---------------- memory model ----------------
    initial begin
        bit          rd_acc, rst_s, pending;
        int          delay;
        logic [31:0] paddr;
        pending = 0; delay = 0; paddr = '0;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            rst_s  = rst_i;
            rd_acc = mem_valid_o && mem_ready_i && !mem_we_o && !rst_i;
            if (rd_acc) paddr = mem_addr_o;
            @(posedge clk); #1;
            mem_rvalid_i = 0;
            if (rst_s) pending = 0;
            else if (rd_acc) begin
                pending = 1;
                delay   = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (pending) begin
                if (delay == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i  = mem_word(paddr);
                    pending      = 0;
                end else delay--;
            end else if ($urandom_range(0, 9) == 0) begin
                // Stray read data while no read is outstanding must be ignored.
                mem_rvalid_i = 1;
                mem_rdata_i  = $urandom;
            end
            mem_ready_i = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- response back-pressure ----------------
    initial begin
        rd_resp_ready_i = 0; wr_resp_ready_i = 0;
        forever begin
            @(posedge clk); #1;
            rd_resp_ready_i = ($urandom_range(0, 99) < rresp_pct);
            wr_resp_ready_i = ($urandom_range(0, 99) < 60);
        end
    end

    // ---------------- monitors ----------------
    initial begin : mon_mem
        logic [31:0] a;
        wr_cmd_t     w;
        forever begin
            @(negedge clk);
            if (!rst_i && mem_valid_o && mem_ready_i) begin
                if (!mem_we_o) begin
                    if (rd_cmd_q.size() == 0) check("mem_rd_unexpected", mem_valid_o, 0);
                    else begin
                        a = rd_cmd_q.pop_front();
                        check("mem_rd_addr", mem_addr_o, a);
                        check("mem_rd_be", mem_be_o, {BW{1'b1}});
                    end
                end else begin
                    if (wr_cmd_q.size() == 0) check("mem_wr_unexpected", mem_valid_o, 0);
                    else begin
                        w = wr_cmd_q.pop_front();
                        check("mem_wr_addr", mem_addr_o, w.addr);
                        check("mem_wr_data", mem_wdata_o, w.data);
                        check("mem_wr_be", mem_be_o, w.be);
                    end
                end
            end
        end
    end

    initial begin : mon_rd_resp
        rd_exp_t     e;
        bit          stall;
        logic [38:0] held;
        stall = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst_i) stall = 0;
            else begin
                if (stall) begin
                    check("rd_resp_hold_valid", rd_resp_valid_o, 1);
                    check("rd_resp_hold_payload", {rd_resp_data_o, rd_resp_id_o, rd_resp_last_o}, held);
                end
                if (rd_resp_valid_o && rd_resp_ready_i) begin
                    rd_resp_cnt++;
                    if (rd_resp_q.size() == 0) check("rd_resp_unexpected", rd_resp_valid_o, 0);
                    else begin
                        e = rd_resp_q.pop_front();
                        check("rd_resp_data", rd_resp_data_o, e.data);
                        check("rd_resp_id", rd_resp_id_o, e.id);
                        check("rd_resp_last", rd_resp_last_o, e.last);
                    end
                end
                stall = rd_resp_valid_o && !rd_resp_ready_i;
                held  = {rd_resp_data_o, rd_resp_id_o, rd_resp_last_o};
            end
        end
    end

    initial begin : mon_wr_resp
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && wr_resp_valid_o && wr_resp_ready_i) begin
                if (wr_resp_q.size() == 0) check("wr_resp_unexpected", wr_resp_valid_o, 0);
                else begin
                    e = wr_resp_q.pop_front();
                    check("wr_resp_id", wr_resp_id_o, e.id);
                    check("wr_resp_err", wr_resp_err_o, e.err);
                end
            end
        end
    end

    initial begin : mon_grant
        forever begin
            @(negedge clk);
            if (!rst_i && rd_req_valid_i && rd_req_ready_o) grant_log.push_back(0);
            if (!rst_i && wr_req_valid_i && wr_req_ready_o) grant_log.push_back(1);
        end
    end

    // ---------------- stimulus tasks (entered at posedge + 1) ----------------
    task automatic send_rd(input logic [31:0] addr, input int len, input logic [IW-1:0] id);
        logic [31:0] a;
        bit          got;
        int          n;
        a = addr; got = 0; n = 0;
        for (int i = 0; i <= len; i++) begin
            rd_cmd_q.push_back(a);
            rd_resp_q.push_back(rd_exp_t'{data: mem_word(a), id: id, last: (i == len)});
            a = a + 32'd4;
        end
        rd_req_valid_i = 1; rd_req_addr_i = addr; rd_req_len_i = LW'(len); rd_req_id_i = id;
        while (!got && n < BUDGET) begin
            @(negedge clk); got = rd_req_ready_o;
            @(posedge clk); #1; n++;
        end
        rd_req_valid_i = 0;
        check("rd_req_granted", got, 1);
    endtask

    // Beat data, enables and last flags come from wd/wbe/wl.
    task automatic send_wr(input logic [31:0] addr, input int len, input logic [IW-1:0] id);
        logic [31:0] a;
        logic        err;
        bit          got;
        int          n, i;
        a = addr; err = 0; got = 0; n = 0; i = 0;
        for (int k = 0; k <= len; k++) begin
            wr_cmd_q.push_back(wr_cmd_t'{addr: a, data: wd[k], be: wbe[k]});
            if (wl[k] != (k == len)) err = 1;
            a = a + 32'd4;
        end
        wr_resp_q.push_back(wr_exp_t'{id: id, err: err});
        wr_req_valid_i = 1; wr_req_addr_i = addr; wr_req_len_i = LW'(len); wr_req_id_i = id;
        while (!got && n < BUDGET) begin
            @(negedge clk); got = wr_req_ready_o;
            @(posedge clk); #1; n++;
        end
        wr_req_valid_i = 0;
        check("wr_req_granted", got, 1);
        n = 0;
        while (got && i <= len && n < BUDGET) begin
            wdata_valid_i = ($urandom_range(0, 3) != 0);
            wdata_i = wd[i]; wdata_be_i = wbe[i]; wdata_last_i = wl[i];
            @(negedge clk); if (wdata_valid_i && wdata_ready_o) i++;
            @(posedge clk); #1; n++;
        end
        wdata_valid_i = 0; wdata_last_i = 0;
        check("wr_beats_consumed", i, len + 1);
    endtask

    task automatic fill_wr(input int len, input int flip_beat);
        for (int k = 0; k <= len; k++) begin
            wd[k]  = $urandom;
            wbe[k] = BW'($urandom_range(1, (1 << BW) - 1));
            wl[k]  = (k == len);
        end
        if (flip_beat >= 0) wl[flip_beat] = ~wl[flip_beat];
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rd_resp_q.size() + rd_cmd_q.size() + wr_cmd_q.size() + wr_resp_q.size()) != 0 && n < 20000) begin
            @(posedge clk); n++;
        end
        #1;
        check("queues_drained", rd_resp_q.size() + rd_cmd_q.size() + wr_cmd_q.size() + wr_resp_q.size(), 0);
    endtask

    task automatic rd_stream(input int nb);
        int len;
        for (int b = 0; b < nb; b++) begin
            len = (b == 5) ? 255 : int'($urandom_range(0, 15));
            send_rd($urandom & 32'hFFFF_FFFC, len, IW'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wr_stream(input int nb);
        int len;
        for (int b = 0; b < nb; b++) begin
            len = (b == 7) ? 255 : int'($urandom_range(0, 15));
            fill_wr(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1);
            send_wr($urandom & 32'hFFFF_FFFC, len, IW'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_grants[5] = '{0, 1, 0, 1, 0};
        int base, n;

        rst_i = 1;
        rd_req_valid_i = 1; rd_req_addr_i = '0; rd_req_len_i = '0; rd_req_id_i = '0;
        wr_req_valid_i = 1; wr_req_addr_i = '0; wr_req_len_i = '0; wr_req_id_i = '0;
        wdata_valid_i = 0; wdata_i = '0; wdata_be_i = '0; wdata_last_i = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_rd_req_ready", rd_req_ready_o, 0);
        check("rst_wr_req_ready", wr_req_ready_o, 0);
        check("rst_wdata_ready", wdata_ready_o, 0);
        check("rst_rd_resp_valid", rd_resp_valid_o, 0);
        check("rst_wr_resp_valid", wr_resp_valid_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_rd_resp_data", rd_resp_data_o, 0);
        check("rst_wr_resp_err", wr_resp_err_o, 0);
        @(posedge clk); #1;
        rst_i = 0; rd_req_valid_i = 0; wr_req_valid_i = 0;

        // Contested start: read first, then the write; 8-beat read with stalls,
        // 4-beat write whose second beat has byte enables 0x3.
        rresp_pct = 50;
        fill_wr(3, -1);
        wbe[1] = 4'h3;
        fork
            send_rd(32'h0000_2000, 7, 6'd1);
            send_wr(32'h0000_0040, 3, 6'd3);
        join
        wait_idle();

        // Single-beat read, fixed memory latency.
        mem_img[32'h100] = 32'hDEAD_BEEF;
        mem_lat = 2;
        send_rd(32'h0000_0100, 0, 6'd5);
        wait_idle();
        mem_lat = -1;

        // Contested again after a read grant: write wins. The write flags last
        // on beat 2; the read wraps through address zero.
        fill_wr(3, 1);
        fork
            send_wr(32'h0000_0080, 3, 6'd4);
            send_rd(32'hFFFF_FFF8, 3, 6'd7);
        join
        wait_idle();

        check("grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("grant_order", grant_log[i], exp_grants[i]);

        // Missing last on the final beat also reports an error.
        fill_wr(2, 2);
        send_wr(32'h0000_0200, 2, 6'd12);
        wait_idle();

        // Reset during the third beat of an 8-beat read.
        rresp_pct = 100;
        base = rd_resp_cnt;
        send_rd(32'h0000_3000, 7, 6'd9);
        n = 0;
        while (rd_resp_cnt < base + 2 && n < BUDGET) begin @(posedge clk); n++; end
        #1;
        check("rst_mid_progress", rd_resp_cnt - base, 2);
        rst_i = 1;
        rd_cmd_q.delete();
        rd_resp_q.delete();
        @(posedge clk); #1;
        rst_i = 0;
        @(negedge clk);
        check("midrst_mem_valid", mem_valid_o, 0);
        check("midrst_rd_resp_valid", rd_resp_valid_o, 0);
        check("midrst_wr_resp_valid", wr_resp_valid_o, 0);
        repeat (20) @(posedge clk);
        #1;
        send_rd(32'h0000_0500, 2, 6'd10);
        wait_idle();

        // Randomized concurrent traffic.
        rresp_pct = 60;
        fork
            rd_stream(12);
            wr_stream(12);
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
